// File: rtl/pool_scheduler.sv
// pool_scheduler
// ---------------
// Time-shares a single 2x2 max-pooling unit between SA_NUM systolic-array
// output lanes. Each lane gathers four elements into a private window
// buffer. Full windows are granted round-robin and streamed to the pooling
// unit as four back-to-back enabled beats, followed by one drain beat. The
// unit's max is captured and returned on a valid/ready result port that is
// tagged with the source lane.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     per-lane element handshake
//   in_data               per-lane element, lane i at [i*W +: W]
//   cfg_mode, cfg_signed  compare configuration, sampled at grant
//   pool_enable           pooling unit enable (low clears the unit)
//   out_model, Sx         configuration latched for the current window
//   pool_data             element streamed to the pooling unit
//   pool_max              pooling unit result, valid in the drain beat
//   res_valid/res_ready   result handshake
//   res_data, res_lane    captured window max and its source lane
//   busy                  scheduler is not idle
module pool_scheduler #(
    parameter int SA_NUM          = 3,
    parameter int SA_OUTPUT_WIDTH = 14,
    parameter int LANE_W          = $clog2(SA_NUM)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [SA_NUM-1:0]                 in_valid,
    output logic [SA_NUM-1:0]                 in_ready,
    input  logic [SA_NUM*SA_OUTPUT_WIDTH-1:0] in_data,
    input  logic                              cfg_mode,
    input  logic                              cfg_signed,
    output logic                              pool_enable,
    output logic                              out_model,
    output logic                              Sx,
    output logic [SA_OUTPUT_WIDTH-1:0]        pool_data,
    input  logic [SA_OUTPUT_WIDTH-1:0]        pool_max,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [SA_OUTPUT_WIDTH-1:0]        res_data,
    output logic [LANE_W-1:0]                 res_lane,
    output logic                              busy
);

    localparam int W = SA_OUTPUT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [LANE_W-1:0]   lane_r;
    logic [LANE_W-1:0]   lane_next_s;
    logic [1:0]          beat_r;
    logic [1:0]          beat_next_s;
    logic [LANE_W-1:0]   rr_r;
    logic [LANE_W-1:0]   rr_next_s;
    logic                grant_s;

    logic [2:0]          cnt_r      [SA_NUM];
    logic [2:0]          cnt_next_s [SA_NUM];
    logic [W-1:0]        buf_r      [SA_NUM][4];
    logic [SA_NUM-1:0]   full_s;
    logic [SA_NUM-1:0]   accept_s;

    logic                arb_found_s;
    logic [LANE_W-1:0]   arb_lane_s;
    logic [LANE_W:0]     arb_sum_s;
    logic [LANE_W-1:0]   arb_idx_s;

    logic [SA_NUM-1:0]   ready_r;
    logic                pool_enable_r;
    logic [W-1:0]        pool_data_r;
    logic                out_model_r;
    logic                sx_r;
    logic                res_valid_r;
    logic [W-1:0]        res_data_r;
    logic [LANE_W-1:0]   res_lane_r;
    logic                busy_r;

    assign in_ready    = ready_r;
    assign pool_enable = pool_enable_r;
    assign pool_data   = pool_data_r;
    assign out_model   = out_model_r;
    assign Sx          = sx_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_lane    = res_lane_r;
    assign busy        = busy_r;

    // Lane fill status, acceptance and next count (clears on the last feed beat).
    always_comb begin
        for (int i = 0; i < SA_NUM; i++) begin
            full_s[i]     = (cnt_r[i] == 3'd4);
            accept_s[i]   = in_valid[i] & (cnt_r[i] != 3'd4);
            cnt_next_s[i] = cnt_r[i];
            if ((state_r == ST_FEED) && (lane_r == LANE_W'(i)) && (beat_r == 2'd3)) begin
                cnt_next_s[i] = 3'd0;
            end else if (accept_s[i]) begin
                cnt_next_s[i] = cnt_r[i] + 3'd1;
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
        end
    end

    // Round-robin search for the first full lane starting at the rr pointer.
    always_comb begin
        arb_found_s = 1'b0;
        arb_lane_s  = '0;
        arb_sum_s   = '0;
        arb_idx_s   = '0;
        for (int j = 0; j < SA_NUM; j++) begin
            // rr_r and j are both below SA_NUM, so one subtraction wraps the sum.
            arb_sum_s = {1'b0, rr_r} + (LANE_W+1)'(j);
            if (arb_sum_s >= (LANE_W+1)'(SA_NUM)) begin
                arb_sum_s = arb_sum_s - (LANE_W+1)'(SA_NUM);
            end else begin
                arb_sum_s = arb_sum_s;
            end
            arb_idx_s = arb_sum_s[LANE_W-1:0];
            if (!arb_found_s && full_s[arb_idx_s]) begin
                arb_found_s = 1'b1;
                arb_lane_s  = arb_idx_s;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
        if (arb_lane_s == LANE_W'(SA_NUM - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = arb_lane_s + LANE_W'(1);
        end
    end

    // Scheduler next-state logic.
    always_comb begin
        state_next_s = state_r;
        lane_next_s  = lane_r;
        beat_next_s  = beat_r;
        grant_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_found_s) begin
                    state_next_s = ST_FEED;
                    lane_next_s  = arb_lane_s;
                    beat_next_s  = 2'd0;
                    grant_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (beat_r == 2'd3) begin
                    state_next_s = ST_DRAIN;
                    beat_next_s  = 2'd0;
                end else begin
                    beat_next_s  = beat_r + 2'd1;
                end
            end
            ST_DRAIN: begin
                state_next_s = ST_OUT;
            end
            ST_OUT: begin
                if (res_ready) begin
                    if (arb_found_s) begin
                        state_next_s = ST_FEED;
                        lane_next_s  = arb_lane_s;
                        beat_next_s  = 2'd0;
                        grant_s      = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                beat_next_s  = 2'd0;
            end
        endcase
    end

    // Scheduler state, current lane, beat counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            lane_r  <= '0;
            beat_r  <= 2'd0;
            rr_r    <= '0;
        end else begin
            state_r <= state_next_s;
            lane_r  <= lane_next_s;
            beat_r  <= beat_next_s;
            if (grant_s) begin
                rr_r <= rr_next_s;
            end
        end
    end

    // Per-lane gather buffers and fill counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SA_NUM; i++) begin
                cnt_r[i] <= 3'd0;
                for (int s = 0; s < 4; s++) begin
                    buf_r[i][s] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < SA_NUM; i++) begin
                cnt_r[i] <= cnt_next_s[i];
                if (accept_s[i]) begin
                    buf_r[i][cnt_r[i][1:0]] <= in_data[i*W +: W];
                end
            end
        end
    end

    // Registered outputs, derived from the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r       <= '1;
            pool_enable_r <= 1'b0;
            pool_data_r   <= '0;
            out_model_r   <= 1'b0;
            sx_r          <= 1'b0;
            res_valid_r   <= 1'b0;
            res_data_r    <= '0;
            res_lane_r    <= '0;
            busy_r        <= 1'b0;
        end else begin
            for (int i = 0; i < SA_NUM; i++) begin
                ready_r[i] <= (cnt_next_s[i] != 3'd4);
            end
            pool_enable_r <= (state_next_s == ST_FEED) || (state_next_s == ST_DRAIN);
            pool_data_r   <= (state_next_s == ST_FEED) ? buf_r[lane_next_s][beat_next_s] : '0;
            res_valid_r   <= (state_next_s == ST_OUT);
            busy_r        <= (state_next_s != ST_IDLE);
            // pool_max is only guaranteed valid during the drain beat.
            if (state_r == ST_DRAIN) begin
                res_data_r <= pool_max;
                res_lane_r <= lane_r;
            end
            if (grant_s) begin
                out_model_r <= cfg_mode;
                sx_r        <= cfg_signed;
            end
        end
    end

endmodule

// File: tb/tb_pool_scheduler.sv
// Testbench for pool_scheduler: directed scenarios plus randomized traffic,
// all checked each cycle against a transaction-level reference model that
// tracks lane queues and the time elapsed since each grant.
module tb_pool_scheduler;

    localparam int N  = 3;
    localparam int W  = 14;
    localparam int LW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*W-1:0]  in_data;
    logic            cfg_mode;
    logic            cfg_signed;
    logic            pool_enable;
    logic            out_model;
    logic            Sx;
    logic [W-1:0]    pool_data;
    logic [W-1:0]    pool_max;
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_data;
    logic [LW-1:0]   res_lane;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] mq [N][$];
    int           m_act  = 0;
    int           m_age  = 0;
    int           m_lane = 0;
    int           m_rr   = 0;
    int           m_om   = 0;
    int           m_sx   = 0;
    int           m_rd   = 0;
    int           m_rl   = 0;
    int           got [$];
    int           rr_exp [5] = '{0, 1, 2, 0, 2};

    pool_scheduler #(.SA_NUM(N), .SA_OUTPUT_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .cfg_mode    (cfg_mode),
        .cfg_signed  (cfg_signed),
        .pool_enable (pool_enable),
        .out_model   (out_model),
        .Sx          (Sx),
        .pool_data   (pool_data),
        .pool_max    (pool_max),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_lane    (res_lane),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_idle();
        reset      = 1'b0;
        in_valid   = '0;
        in_data    = '0;
        cfg_mode   = 1'b0;
        cfg_signed = 1'b0;
        res_ready  = 1'b1;
        pool_max   = '0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        bit acc [N];
        bit can_arb;
        int g;
        int idx;
        if (res_valid && res_ready) got.push_back(int'(res_lane));
        if (reset) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_act = 0; m_age = 0; m_lane = 0; m_rr = 0;
            m_om = 0; m_sx = 0; m_rd = 0; m_rl = 0;
            return;
        end
        for (int i = 0; i < N; i++) acc[i] = in_valid[i] && (mq[i].size() < 4);
        can_arb = (m_act == 0) || (m_age >= 6 && res_ready);
        g = -1;
        if (can_arb) begin
            for (int j = 0; j < N; j++) begin
                idx = (m_rr + j) % N;
                if (g < 0 && mq[idx].size() == 4) g = idx;
            end
        end
        if (m_act != 0 && m_age == 5) begin
            m_rd = int'(pool_max);
            m_rl = m_lane;
        end
        if (m_act != 0 && m_age == 4) mq[m_lane].delete();
        for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(in_data[i*W +: W]);
        if (can_arb) begin
            if (g >= 0) begin
                m_act = 1; m_age = 1; m_lane = g; m_rr = (g + 1) % N;
                m_om = int'(cfg_mode); m_sx = int'(cfg_signed);
            end else begin
                m_act = 0; m_age = 0;
            end
        end else if (m_act != 0 && m_age < 6) begin
            m_age++;
        end
    endtask

    task automatic compare_all();
        logic [W-1:0] exp_pd;
        logic [N-1:0] exp_rdy;
        exp_pd = '0;
        if (m_act != 0 && m_age >= 1 && m_age <= 4) exp_pd = mq[m_lane][m_age-1];
        for (int i = 0; i < N; i++) exp_rdy[i] = (mq[i].size() < 4);
        check_value("busy",        busy,        m_act);
        check_value("pool_enable", pool_enable, (m_act != 0 && m_age >= 1 && m_age <= 5));
        check_value("pool_data",   pool_data,   exp_pd);
        check_value("res_valid",   res_valid,   (m_act != 0 && m_age >= 6));
        check_value("res_data",    res_data,    m_rd);
        check_value("res_lane",    res_lane,    m_rl);
        check_value("out_model",   out_model,   m_om);
        check_value("Sx",          Sx,          m_sx);
        check_value("in_ready",    in_ready,    exp_rdy);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Fill one lane with 5,9,3,7 and follow the window through to its result.
    task automatic single_window(input int lane, input logic [W-1:0] pm, input string tag);
        logic [W-1:0] d [4];
        int pe;
        int first;
        int rdat;
        int rl;
        d[0] = 14'd5; d[1] = 14'd9; d[2] = 14'd3; d[3] = 14'd7;
        drive_idle();
        cfg_mode = 1'b1;
        pool_max = pm;
        for (int k = 0; k < 4; k++) begin
            in_valid = '0;
            in_valid[lane] = 1'b1;
            in_data = '0;
            in_data[lane*W +: W] = d[k];
            tick();
        end
        in_valid = '0;
        pe = 0; first = 0; rdat = 0; rl = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (pool_enable) pe++;
            if (res_valid && first == 0) begin
                first = k; rdat = int'(res_data); rl = int'(res_lane);
            end
        end
        check_value({tag, "_pe_cycles"}, pe, 5);
        check_value({tag, "_res_latency"}, first, 6);
        check_value({tag, "_res_data"}, rdat, pm);
        check_value({tag, "_res_lane"}, rl, lane);
    endtask

    initial begin
        int low;
        int waited;

        // Reset state
        do_reset();
        check_value("rst_pool_enable", pool_enable, 0);
        check_value("rst_in_ready", in_ready, 3'b111);

        // Single lane, unsigned full mode
        single_window(0, 14'd9, "single");

        // Round-robin: all three lanes full at once, then lanes 0 and 2
        do_reset();
        got.delete();
        for (int k = 0; k < 4; k++) begin
            in_valid = 3'b111;
            for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
            pool_max = W'($urandom);
            tick();
        end
        in_valid = '0;
        for (int k = 0; k < 24; k++) begin pool_max = W'($urandom); tick(); end
        for (int k = 0; k < 4; k++) begin
            in_valid = 3'b101;
            for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
            tick();
        end
        in_valid = '0;
        for (int k = 0; k < 16; k++) begin pool_max = W'($urandom); tick(); end
        check_value("rr_count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++) check_value("rr_order", got[k], rr_exp[k]);

        // Back-pressure and config latch
        do_reset();
        res_ready = 1'b0;
        pool_max  = 14'h2A5;
        for (int k = 0; k < 4; k++) begin
            in_valid = 3'b010;
            in_data[W +: W] = W'($urandom);
            tick();
        end
        in_valid = '0;
        waited = 0;
        while (!res_valid && waited < 12) begin tick(); waited++; end
        if (!res_valid) check_value("bp_timeout", 0, 1);
        for (int k = 0; k < 10; k++) begin
            in_valid = 3'b001;
            in_data[0 +: W] = W'($urandom);
            pool_max = W'($urandom);
            tick();
            check_value("bp_res_valid", res_valid, 1);
            check_value("bp_pool_enable", pool_enable, 0);
            check_value("bp_res_lane", res_lane, 1);
            check_value("bp_res_data", res_data, 14'h2A5);
        end
        check_value("bp_full_in_ready", in_ready[0], 0);
        in_valid   = '0;
        cfg_signed = 1'b1;
        cfg_mode   = 1'b0;
        res_ready  = 1'b1;
        tick();
        check_value("bp_grant", pool_enable, 1);
        cfg_signed = 1'b0;
        cfg_mode   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_value("cfg_Sx", Sx, 1);
            check_value("cfg_out_model", out_model, 0);
        end
        for (int k = 0; k < 4; k++) tick();

        // Buffer boundary: lane 1 offers a fifth element while full
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 3'b010;
            in_data[W +: W] = W'(k + 20);
            tick();
        end
        in_data[W +: W] = 14'h155;
        low = 0;
        while (!in_ready[1] && low < 12) begin tick(); low++; end
        check_value("bnd_low_cycles", low, 5);
        tick();
        in_valid = '0;
        for (int k = 0; k < 6; k++) tick();
        check_value("bnd_in_ready", in_ready[1], 1);

        // Reset in the middle of a feed
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 3'b001;
            in_data[0 +: W] = W'($urandom);
            tick();
        end
        in_valid = '0;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_value("mid_rst_pool_enable", pool_enable, 0);
        check_value("mid_rst_res_valid", res_valid, 0);
        check_value("mid_rst_in_ready", in_ready, 3'b111);
        check_value("mid_rst_busy", busy, 0);
        single_window(2, 14'd9, "post_rst");

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            reset      = ($urandom_range(0, 199) == 0);
            in_valid   = N'($urandom);
            for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
            cfg_mode   = 1'($urandom);
            cfg_signed = 1'($urandom);
            res_ready  = ($urandom_range(0, 9) < 7);
            pool_max   = W'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_scheduler.md
Name: pool_scheduler

Overview:
- Time-shares one 2x2 max-pooling unit between SA_NUM systolic-array output lanes.
- Each lane's results are gathered into a private 4-entry window buffer.
- Full windows are granted round-robin and streamed to the pooling unit as 4 back-to-back enabled beats. The unit's max is then captured and returned on a valid/ready result port tagged with the source lane.
- Sits between the SA output collectors and the pooling datapath / output writeback.

Parameters:
- SA_NUM, 3, number of SA output lanes (≥2).
- SA_OUTPUT_WIDTH, 14, element width (W).
- LANE_W, $clog2(SA_NUM), lane-id width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  SA_NUM  per-lane element valid.
- in_ready  out  SA_NUM  per-lane element ready.
- in_data  in  SA_NUM*W  per-lane element; lane i at [i*W +: W].
- cfg_mode  in  1  1 = full-width compare, 0 = dual 7-bit packed compare; sampled at grant.
- cfg_signed  in  1  1 = signed compare; sampled at grant.
- pool_enable  out  1  pooling unit enable; low clears the unit.
- out_model  out  1  latched cfg_mode for the current window.
- Sx  out  1  latched cfg_signed for the current window.
- pool_data  out  W  element to pooling unit.
- pool_max  in  W  pooling unit result.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  W  captured window max.
- res_lane  out  LANE_W  lane that produced res_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, has priority):
  - state=IDLE, all lane counts=0, rr pointer=0.
  - pool_enable=0, pool_data=0, out_model=0, Sx=0.
  - res_valid=0, res_data=0, res_lane=0, busy=0.
  - Reset mid-window discards all buffered data and any pending result; pool_enable is low the cycle after reset is sampled.
- Gather buffers:
  - Each lane has cnt[i] in 0..4 and in_ready[i] = (cnt[i] < 4).
  - An element is accepted when in_valid & in_ready; it is stored at slot cnt[i], and cnt[i] increments.
  - The buffer is full when cnt[i] == 4.
  - cnt[i] clears to 0 at the clock edge ending the 4th FEED beat of lane i. in_ready[i] stays low during that beat and rises the next cycle.
- Arbitration:
  - Evaluated in IDLE, and in OUT on the res handshake cycle.
  - Grant goes to the first full lane found searching from the rr pointer upward with wrap-around.
  - On grant to lane k: rr pointer = (k+1) mod SA_NUM; cfg_mode/cfg_signed are latched into out_model/Sx; go to FEED.
  - If no lane is full: go to, or stay in, IDLE.
  - Config changes after grant do not affect the current window.
- FSM:
  - IDLE: pool_enable=0.
  - FEED: pool_enable=1; pool_data = buffer[k][beat], beat 0..3. One beat per cycle, no stalls. After beat 3 → DRAIN.
  - DRAIN: pool_enable=1, pool_data=0. pool_max is valid this cycle (pooling-unit contract) and is registered into res_data; res_lane=k. → OUT.
  - OUT: pool_enable=0 (clears the unit); res_valid=1. res_data and res_lane are held stable until res_ready. On handshake, arbitrate: grant → FEED, else → IDLE.
  - At least one cycle with pool_enable low separates consecutive windows.
- Latency: with a lane full in IDLE at cycle t:
  - FEED beats at t+1..t+4.
  - DRAIN at t+5.
  - res_valid first high at t+6.
  - With res_ready tied high, a new window can start every 6 cycles.
- Back-pressure: while OUT waits on res_ready, lanes keep filling. Full lanes hold in_ready low; no data is dropped.
- Simultaneous events:
  - Fill of another lane during FEED is allowed.
  - A lane whose 4th element arrives in the same cycle as arbitration is not yet full and is not granted that cycle.
- pool_data and out_model/Sx are registered outputs; res_data is a register, never a combinational copy of pool_max.

Test Plan:
- Single lane, unsigned full mode:
  - Lane 0 sends 5,9,3,7; pooling model returns 9 in DRAIN.
  - Required: pool_enable high exactly 5 cycles; pool_data 5,9,3,7,0; res_valid at t+6 with res_data=9, res_lane=0.
- Round-robin:
  - All three lanes full simultaneously in IDLE, rr=0.
  - Required: grants in order 0,1,2; then refill lane 0 and lane 2 → next grant lane 0.
- Back-pressure:
  - res_ready held low 10 cycles in OUT.
  - Required: res_data/res_lane stable throughout; pool_enable=0; full lanes show in_ready=0; no grant until handshake.
- Config latch:
  - cfg_signed=1, cfg_mode=0 at grant, toggled to 0/1 during FEED.
  - Required: Sx=1, out_model=0 through FEED and DRAIN.
- Buffer boundary:
  - Lane 1 presents a 5th element while full.
  - Required: in_ready[1]=0 until the cycle after its 4th FEED beat; element accepted then; cnt becomes 1.
- Reset mid-FEED:
  - Assert reset at beat 2.
  - Required: next cycle pool_enable=0, res_valid=0, all in_ready=1, rr pointer=0; subsequent window from lane 2 behaves as in the first scenario.
